// File: rtl/aes_pkg.sv
// Shared definitions for the AES host-side block transmitters/collectors.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BYTE_W      = 8;

    // Byte-index helpers: byte 0 lives in [127:120], byte 15 in [7:0].
    localparam logic [3:0] FIRST_BYTE = 4'd0;
    localparam logic [3:0] LAST_BYTE  = 4'd15;

    // Host FSM state encoding.
    typedef logic [1:0] host_state_t;
    localparam host_state_t ST_IDLE = 2'd0;
    localparam host_state_t ST_LOAD = 2'd1;
    localparam host_state_t ST_WAIT = 2'd2;
    localparam host_state_t ST_HOLD = 2'd3;

    // Returns byte idx of a 128-bit block (byte 0 = most significant).
    function automatic logic [7:0] block_byte(input logic [127:0] blk, input logic [3:0] idx);
        logic [127:0] shifted;
        shifted = blk << {idx, 3'b000};
        return shifted[127:120];
    endfunction

endpackage

// File: rtl/aes_ct_capture.sv
// Byte shift register with a 16-byte window tap and a snapshot register.
// Stage 0 holds the newest byte; the window covers stages TAP+15 (oldest,
// mapped to [127:120]) down to TAP.
module aes_ct_capture #(
    parameter int DEPTH = 19,
    parameter int TAP   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         snap_en,
    input  logic [7:0]   din,
    output logic [127:0] window
);

    logic [DEPTH*8-1:0] sr;
    logic [127:0]       tap_bytes;

    // Shift the newest byte in at the low end of the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[DEPTH*8-9:0], din};
        end
    end

    // Window byte gi (0 = oldest) comes from stage TAP+15-gi.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_tap
            assign tap_bytes[127-8*gi -: 8] = sr[8*(TAP+15-gi) +: 8];
        end
    endgenerate

    // Freeze the window into the output register on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
        end else if (snap_en) begin
            window <= tap_bytes;
        end
    end

endmodule

// File: rtl/aes_block_host.sv
// Host-side transmitter/collector for the byte-serial AES-128 core:
// serialises a plaintext block into the core, captures the ciphertext
// stream and hands it back as one 128-bit word.
module aes_block_host
    import aes_pkg::*;
#(
    parameter int DONE_LAG       = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_plain,
    output logic         start_system,
    output logic [7:0]   data_in,
    input  logic [7:0]   out_ADDROUND,
    input  logic         DONE,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [127:0] ct_data,
    output logic         busy,
    output logic         err
);

    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    host_state_t      state, state_next;
    logic             ready;
    logic [127:0]     plain;
    logic [3:0]       byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             done_d;
    logic             accept;
    logic             done_rise;
    logic             timeout;

    assign accept    = (state == ST_IDLE) && ready && blk_valid;
    assign done_rise = DONE && !done_d;
    // A genuine DONE edge wins over a timeout landing in the same cycle.
    assign timeout   = (state == ST_WAIT) && (tmo_cnt == TMO_LIMIT) && !done_rise;

    // Next-state selection for the IDLE/LOAD/WAIT/HOLD sequence.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)                   state_next = ST_LOAD;
            ST_LOAD: if (byte_cnt == LAST_BYTE)    state_next = ST_WAIT;
            ST_WAIT: begin
                if (done_rise)                     state_next = ST_HOLD;
                else if (timeout)                  state_next = ST_IDLE;
            end
            ST_HOLD: if (ct_ready)                 state_next = ST_IDLE;
            default:                               state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Registered ready keeps blk_ready low throughout reset and makes a
    // handoff cycle never double as an accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready <= 1'b0;
        else     ready <= (state_next == ST_IDLE);
    end

    // Plaintext latch on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         plain <= '0;
        else if (accept) plain <= blk_plain;
    end

    // Byte counter: byte 0 goes out in the accept cycle, so LOAD starts at 1
    // and the 4-bit counter wraps back to 0 as LOAD ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    byte_cnt <= 4'd0;
        else if (accept)            byte_cnt <= 4'd1;
        else if (state == ST_LOAD)  byte_cnt <= byte_cnt + 4'd1;
    end

    // Timeout counter: held clear through LOAD, saturating count in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_LOAD) begin
            tmo_cnt <= '0;
        end else if ((state == ST_WAIT) && (tmo_cnt != {TMO_W{1'b1}})) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Delayed DONE for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_d <= 1'b0;
        else     done_d <= DONE;
    end

    aes_ct_capture #(
        .DEPTH (AES_BLOCK_BYTES + DONE_LAG),
        .TAP   (DONE_LAG)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .shift_en (state == ST_WAIT),
        .snap_en  ((state == ST_WAIT) && done_rise),
        .din      (out_ADDROUND),
        .window   (ct_data)
    );

    // Output decode; byte 0 bypasses the latch so it leaves in the accept cycle.
    always_comb begin
        data_in = 8'h00;
        if (accept)                data_in = block_byte(blk_plain, FIRST_BYTE);
        else if (state == ST_LOAD) data_in = block_byte(plain, byte_cnt);
    end

    assign blk_ready    = ready;
    assign start_system = accept;
    assign ct_valid     = (state == ST_HOLD);
    assign busy         = (state != ST_IDLE);
    assign err          = timeout;

endmodule

// File: tb/tb_aes_block_host.sv
// Self-checking bench for aes_block_host with a behavioural core model.
module tb_aes_block_host;

    localparam int LAG = 3;
    localparam int TMO = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [127:0] blk_plain = '0;
    logic         start_system;
    logic [7:0]   data_in;
    logic [7:0]   out_ADDROUND = 8'h00;
    logic         DONE = 1'b0;
    logic         ct_valid;
    logic         ct_ready = 1'b0;
    logic [127:0] ct_data;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;
    int blocks = 0;

    always #5 clk = ~clk;

    aes_block_host #(
        .DONE_LAG       (LAG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_plain    (blk_plain),
        .start_system (start_system),
        .data_in      (data_in),
        .out_ADDROUND (out_ADDROUND),
        .DONE         (DONE),
        .ct_valid     (ct_valid),
        .ct_ready     (ct_ready),
        .ct_data      (ct_data),
        .busy         (busy),
        .err          (err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [7:0] nth_byte(input logic [127:0] v, input int k);
        logic [127:0] s;
        s = v >> (8 * (15 - k));
        return s[7:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One block: accept, 15 LOAD cycles, WAIT with a modelled core, then HOLD.
    // The core emits ct bytes starting `gap` cycles into WAIT; DONE rises so
    // that the ciphertext samples sit at D-LAG-16 .. D-LAG-1.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input int gap,
                             input bit spurious, input bit never_done, input int bp,
                             input int abort_at);
        logic [7:0]   seen[$];
        logic [7:0]   b;
        logic [127:0] exp_ct;
        int           d_idx;
        int           limit;

        // Accept cycle.
        next_cycle();
        DONE = 1'b0; out_ADDROUND = 8'h00; ct_ready = 1'b0;
        blk_valid = 1'b1; blk_plain = pt;
        settle();
        chk1("accept_ready", blk_ready, 1'b1);
        chk1("accept_start", start_system, 1'b1);
        chk8("accept_byte0", data_in, nth_byte(pt, 0));

        // LOAD: bytes 1..15, blk_valid noise must be ignored.
        for (int k = 1; k < 16; k++) begin
            next_cycle();
            blk_valid = 1'($urandom_range(0, 1));
            blk_plain = rand128();
            DONE = spurious && (k == 5);
            if (k == abort_at) begin
                rst = 1'b1;
                settle();
                chk1("rst_start", start_system, 1'b0);
                chk8("rst_data_in", data_in, 8'h00);
                chk1("rst_ct_valid", ct_valid, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_blk_ready", blk_ready, 1'b0);
                chk128("rst_ct_data", ct_data, 128'h0);
                next_cycle();
                rst = 1'b0; blk_valid = 1'b0; DONE = 1'b0;
                settle();
                chk1("rst_exit_busy", busy, 1'b0);
                next_cycle();
                settle();
                chk1("rst_exit_ready", blk_ready, 1'b1);
                $display("block %0d pt=%h aborted by reset at byte %0d", blocks, pt, k);
                blocks++;
                return;
            end
            settle();
            chk8("load_byte", data_in, nth_byte(pt, k));
            chk1("load_start", start_system, 1'b0);
            chk1("load_busy", busy, 1'b1);
        end

        // WAIT: the model records every byte it presents.
        d_idx = gap + 16 + LAG;
        limit = never_done ? TMO + 1 : d_idx + 1;
        for (int w = 0; w < limit; w++) begin
            next_cycle();
            if (w >= gap && w < gap + 16) b = nth_byte(ct, w - gap);
            else                          b = 8'($urandom());
            out_ADDROUND = b;
            seen.push_back(b);
            DONE = !never_done && (w >= d_idx);
            blk_valid = 1'($urandom_range(0, 1));
            settle();
            if (w == 0) chk8("wait_data_zero", data_in, 8'h00);
            chk1("wait_ct_valid", ct_valid, 1'b0);
            chk1("wait_start", start_system, 1'b0);
            if (never_done) chk1("wait_err", err, (w == TMO));
        end

        if (never_done) begin
            next_cycle();
            blk_valid = 1'b0;
            settle();
            chk1("tmo_err_once", err, 1'b0);
            chk1("tmo_busy", busy, 1'b0);
            chk1("tmo_ct_valid", ct_valid, 1'b0);
            chk1("tmo_ready", blk_ready, 1'b1);
            $display("block %0d pt=%h timed out", blocks, pt);
            blocks++;
            return;
        end

        // Reference: the 16 samples at D-LAG-16 .. D-LAG-1.
        exp_ct = '0;
        for (int i = d_idx - LAG - 16; i < d_idx - LAG; i++) exp_ct = {exp_ct[119:0], seen[i]};

        // HOLD with optional backpressure; new offers must not start the core.
        for (int h = 0; h <= bp; h++) begin
            next_cycle();
            DONE = 1'($urandom_range(0, 1));
            out_ADDROUND = 8'($urandom());
            blk_valid = 1'b1;
            blk_plain = rand128();
            ct_ready = (h == bp);
            settle();
            chk1("hold_valid", ct_valid, 1'b1);
            chk128("hold_ct_data", ct_data, exp_ct);
            chk1("hold_blk_ready", blk_ready, 1'b0);
            chk1("hold_start", start_system, 1'b0);
            chk8("hold_data_in", data_in, 8'h00);
        end
        $display("block %0d pt=%h ct=%h backpressure=%0d", blocks, pt, ct_data, bp);
        blocks++;
    endtask

    initial begin
        // Reset state.
        next_cycle();
        chk1("reset_ready", blk_ready, 1'b0);
        chk1("reset_start", start_system, 1'b0);
        chk8("reset_data_in", data_in, 8'h00);
        chk1("reset_ct_valid", ct_valid, 1'b0);
        chk128("reset_ct_data", ct_data, 128'h0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_err", err, 1'b0);
        rst = 1'b0;
        next_cycle();
        chk1("post_reset_ready", blk_ready, 1'b1);

        // FIPS-197 vector with the core producing the known ciphertext.
        run_block(128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 2, 1'b0, 1'b0, 0, 0);
        // Capture window alignment, bytes right at WAIT entry.
        run_block(rand128(), 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, 0, 1'b0, 1'b0, 0, 0);
        // Backpressure, then the next block immediately after the handoff.
        run_block(rand128(), rand128(), 5, 1'b0, 1'b0, 20, 0);
        run_block(rand128(), rand128(), 1, 1'b0, 1'b0, 0, 0);
        // Timeout.
        run_block(rand128(), rand128(), 0, 1'b0, 1'b1, 0, 0);
        // Reset during LOAD byte 7, then a normal block.
        run_block(rand128(), rand128(), 0, 1'b0, 1'b0, 0, 7);
        run_block(128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 1'b0, 1'b0, 0, 0);
        // Spurious DONE during LOAD.
        run_block(rand128(), rand128(), 4, 1'b1, 1'b0, 2, 0);
        // Randomised blocks.
        for (int r = 0; r < 6; r++) begin
            run_block(rand128(), rand128(), $urandom_range(0, 20), 1'($urandom_range(0, 1)),
                      1'b0, $urandom_range(0, 4), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_block_host.md
# aes_block_host

Host-side transmitter/collector for the byte-serial AES-128 encryption core. It accepts a 128-bit plaintext block on a valid/ready handshake and serialises it into the core's `start_system`/`data_in` byte stream. It watches the core's `out_ADDROUND` stream and `DONE` flag, reassembles the 16 ciphertext bytes, and returns them as one 128-bit word on a second valid/ready handshake. It sits between the system bus logic and the encryption core, and shares the core's clock and reset.

## Interface
Parameters:
- `DONE_LAG`, default 3: cycles between the last ciphertext byte on `out_ADDROUND` and the cycle `DONE` rises.
- `TIMEOUT_CYCLES`, default 1023: maximum cycles spent in WAIT before the block aborts.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `blk_valid`  in  1  plaintext block offered.
- `blk_ready`  out  1  block can accept plaintext.
- `blk_plain`  in  128  plaintext; `[127:120]` is byte 0, sent first.
- `start_system`  out  1  one-cycle start pulse to the core.
- `data_in`  out  8  plaintext byte to the core.
- `out_ADDROUND`  in  8  core output byte stream.
- `DONE`  in  1  core completion flag (level).
- `ct_valid`  out  1  ciphertext available.
- `ct_ready`  in  1  consumer accepts ciphertext.
- `ct_data`  out  128  ciphertext; `[127:120]` is byte 0.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse on WAIT timeout.

## Operation
States: IDLE, LOAD, WAIT, HOLD.
- **IDLE:** `blk_ready`=1. If `blk_valid`, latch `blk_plain`, assert `start_system` and drive byte 0 on `data_in` in the same cycle, then go to LOAD with byte counter = 1.
- **LOAD:** drive byte[counter] each cycle for counter 1..15. After byte 15, go to WAIT and clear the timeout counter.
- **WAIT:** each cycle, shift `out_ADDROUND` into a capture shift register of depth `16+DONE_LAG` bytes.
  - On `DONE` rising edge (`DONE`=1 and the registered `DONE_d`=0):
    - load `ct_data` from the 16 oldest bytes of the window; the oldest byte goes to `[127:120]`.
    - go to HOLD.
  - If the timeout counter reaches `TIMEOUT_CYCLES`: pulse `err`, go to IDLE, and do not assert `ct_valid`.
- **HOLD:** `ct_valid`=1 and `ct_data` is stable. When `ct_ready`=1, go to IDLE.
- **Output defaults:**
  - `data_in` is 0x00 outside the IDLE-accept cycle and LOAD.
  - `start_system` is high only in the accept cycle.
- **Ignored inputs:**
  - A `DONE` rising edge during IDLE, LOAD or HOLD is ignored.
  - `blk_valid` outside IDLE is ignored.
- **Counters:** the byte counter is 4 bits and wraps 15→0 on the LOAD exit. The timeout counter is 10 bits minimum and saturates.
- **Reset (any time, including mid-LOAD/WAIT):**
  - state goes to IDLE.
  - all outputs go to 0, except `blk_ready`=1 from the first cycle after reset deasserts.
  - the capture register, `ct_data` and `DONE_d` clear to 0.

## Timing
- Accept in cycle T: `start_system`=1 and `data_in`=byte 0 at T; byte k at T+k; `data_in`=0 from T+16.
- `DONE` rising at cycle D: `ct_valid`=1 from D+1.
- The ciphertext bytes are the `out_ADDROUND` samples at cycles D−DONE_LAG−16 … D−DONE_LAG−1.
- `ct_valid`&&`ct_ready` at cycle H: `blk_ready`=1 at H+1. A block is never accepted in the same cycle as a ciphertext handoff.
- Throughput is one block per core run; there is no overlap of blocks.
- `err` is high for exactly one cycle, at the cycle the timeout counter reaches `TIMEOUT_CYCLES`. IDLE is entered on the next cycle.

## Structure
- **Shared package (`aes_pkg`):**
  - state enum {IDLE, LOAD, WAIT, HOLD}.
  - `AES_BLOCK_BYTES`=16.
  - byte-index helper constants.
- **Sub-module `aes_ct_capture`:** the parameterised byte shift register with window tap and snapshot enable. It is reused later by the decrypt-side host.
- The FSM, counters and handshake logic stay in the top module.

## Test plan
- **FIPS-197 vector:** core key memory 000102…0f, `blk_plain`=00112233445566778899aabbccddeeff → `data_in` sequence 00,11,…,ff on T..T+15; `ct_data`=69c4e0d86a7b0430d8cdb78070b4c55a with `ct_valid`.
- **Capture window:** behavioural core model emits bytes 0xA0..0xAF, then `DONE` rises exactly 3 cycles later → `ct_data`=a0a1…af.
- **Backpressure:** hold `ct_ready`=0 for 20 cycles with `blk_valid`=1 → `ct_data` stable, `blk_ready`=0, no second `start_system`; release → next block accepted one cycle after the handoff.
- **Timeout:** model never raises `DONE`, `TIMEOUT_CYCLES`=50 → `err` pulses once 50 cycles into WAIT; `ct_valid` stays 0; `blk_ready`=1 on the following cycle.
- **Reset mid-operation:** assert `rst` at LOAD byte 7 → `start_system`, `data_in`, `ct_valid` and `busy` are 0 immediately; a new block after reset completes normally with the correct ciphertext.
- **Spurious DONE:** `DONE` pulse during LOAD → ignored, no `ct_valid`; the later genuine `DONE` produces the correct `ct_data`.
